// File: rtl/data_memory_access_unit.sv
// data_memory_access_unit: Data_Memory initiator for byte/half/word loads and stores, with read-modify-write sub-word stores and wait states.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests return Resp_Error without touching memory.
module data_memory_access_unit #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int WAIT_CYCLES   = 0
) (
    input  logic                     DataMemoryAccess_CLOCK_50,
    input  logic                     DataMemoryAccess_RESET_InLow,
    input  logic                     Req_Valid_In,
    output logic                     Req_Ready_Out,
    input  logic                     Req_Write_In,
    input  logic [1:0]               Req_Size_In,
    input  logic                     Req_Signed_In,
    input  logic [31:0]              Req_Address_In,
    input  logic [DATAWIDTH_BUS-1:0] Req_Data_In,
    output logic                     Resp_Valid_Out,
    output logic [DATAWIDTH_BUS-1:0] Resp_Data_Out,
    output logic                     Resp_Error_Out,
    output logic [31:0]              DataMemory_Address_Out,
    output logic [DATAWIDTH_BUS-1:0] DataMemory_Data_Out,
    output logic                     DataMemory_Selector_RD_Out,
    output logic                     DataMemory_Selector_WR_Out,
    input  logic [DATAWIDTH_BUS-1:0] DataMemory_Data_In
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} stateType;
    stateType state, stateNext;
    logic [3:0]  waitCnt;
    logic        reqWrite, reqSigned, respError;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqData, rdWord, respData;
    logic        accept, misaligned, lastCycle;
    logic [4:0]  laneShift;
    logic [31:0] laneMask, loadLane, loadResult;

    assign Req_Ready_Out              = state == IDLE;
    assign Resp_Valid_Out             = state == RESP;
    assign DataMemory_Selector_RD_Out = state == RD;
    assign DataMemory_Selector_WR_Out = state == WR;
    assign DataMemory_Address_Out     = {reqAddr[31:2], 2'b00};
    assign Resp_Data_Out              = respData;
    assign Resp_Error_Out             = respError;
    assign accept                     = Req_Valid_In && Req_Ready_Out;
    assign lastCycle                  = waitCnt == 4'd0;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = Req_Size_In[1] ? |Req_Address_In[1:0] : Req_Size_In[0] & Req_Address_In[0];
`else
    assign misaligned = 1'b0;
`endif

    // Big-endian lanes: byte k sits (3-k) bytes up from bit 0, half h sits (1-h) halves up.
    assign laneShift  = reqSize[0] ? {~reqAddr[1], 4'b0000} : {~reqAddr[1:0], 3'b000};
    assign laneMask   = (reqSize[0] ? 32'h0000FFFF : 32'h000000FF) << laneShift;
    assign loadLane   = DataMemory_Data_In >> laneShift;
    assign loadResult = reqSize[1] ? DataMemory_Data_In
                      : reqSize[0] ? {{16{reqSigned & loadLane[15]}}, loadLane[15:0]}
                      : {{24{reqSigned & loadLane[7]}}, loadLane[7:0]};
    assign DataMemory_Data_Out = reqSize[1] ? reqData
                               : (rdWord & ~laneMask) | ((reqData << laneShift) & laneMask);

    always_ff @(posedge DataMemoryAccess_CLOCK_50 or negedge DataMemoryAccess_RESET_InLow) begin
        if (!DataMemoryAccess_RESET_InLow) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = misaligned ? RESP : (Req_Write_In && Req_Size_In[1]) ? WR : RD;
            RD:   if (lastCycle) stateNext = reqWrite ? WR : RESP;
            WR:   if (lastCycle) stateNext = RESP;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge DataMemoryAccess_CLOCK_50 or negedge DataMemoryAccess_RESET_InLow) begin
        if (!DataMemoryAccess_RESET_InLow) begin
            waitCnt   <= '0;
            reqWrite  <= 1'b0;
            reqSigned <= 1'b0;
            reqSize   <= '0;
            reqAddr   <= '0;
            reqData   <= '0;
            rdWord    <= '0;
            respData  <= '0;
            respError <= 1'b0;
        end else begin
            if (accept) begin
                reqWrite  <= Req_Write_In;
                reqSigned <= Req_Signed_In;
                reqSize   <= Req_Size_In;
                reqAddr   <= Req_Address_In;
                reqData   <= Req_Data_In;
            end
            waitCnt <= (stateNext != state) ? 4'(WAIT_CYCLES) : lastCycle ? waitCnt : waitCnt - 4'd1;
            if (state == RD && lastCycle) rdWord <= DataMemory_Data_In;
            // Only the IDLE->RESP path is a trap; only RD->RESP carries load data.
            if (stateNext == RESP && state != RESP) begin
                respData  <= (state == RD) ? loadResult : '0;
                respError <= state == IDLE;
            end
        end
    end
endmodule
